gru_seq_ctrl: RTL and testbench

Sequencer for the combinational gru_lstm_cell, which uses Q4.12 data (16-bit, 12 fractional bits).
- Holds the nine weight/bias registers, an initial hidden state and a sequence length, all loaded through a config write port.
- Accepts a stream of X samples via valid/ready and drives each one through the cell.
- Waits a fixed settle time, then feeds h_out back as the next h_in and streams each step's h_out out via valid/ready.

---
 rtl/gru_pkg.sv | 34 +++
 rtl/gru_seq_ctrl_if.sv | 40 ++++
 rtl/gru_cfg_regfile.sv | 68 ++++++
 rtl/gru_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_gru_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gru_pkg.sv
// Shared constants for the GRU/LSTM cell sequencer: data format, config map, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gru_pkg;

  // Q4.12 datapath
  localparam int DATA_WIDTH  = 16;
  localparam int FRACT_WIDTH = 12;

  // Number of weight/bias words presented to the cell
  localparam int NUM_WTS = 9;

  // Config address map
  localparam logic [3:0] ADDR_WZ     = 4'd0;
  localparam logic [3:0] ADDR_WR     = 4'd1;
  localparam logic [3:0] ADDR_WH     = 4'd2;
  localparam logic [3:0] ADDR_UZ     = 4'd3;
  localparam logic [3:0] ADDR_UR     = 4'd4;
  localparam logic [3:0] ADDR_UH     = 4'd5;
  localparam logic [3:0] ADDR_BZ     = 4'd6;
  localparam logic [3:0] ADDR_BR     = 4'd7;
  localparam logic [3:0] ADDR_BH     = 4'd8;
  localparam logic [3:0] ADDR_HINIT  = 4'd9;
  localparam logic [3:0] ADDR_SEQLEN = 4'd10;

  // Sequencer FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT_X = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_EMIT   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/gru_seq_ctrl_if.sv
// Bundle of config, X stream, Y stream and cell-facing signals of the sequencer.
// Latency: n/a (wires only).
// Backpressure: x_valid/x_ready and y_valid/y_ready handshakes carried here.
// slave  = sequencer side, master = environment side (config host, streams, cell).
interface gru_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  // config port
  logic                    cfg_we;
  logic [3:0]              cfg_addr;
  logic [DATA_WIDTH-1:0]   cfg_wdata;
  // control
  logic                    start;
  logic                    busy;
  logic                    done;
  // X stream
  logic                    x_valid;
  logic                    x_ready;
  logic [DATA_WIDTH-1:0]   x_data;
  // Y stream
  logic                    y_valid;
  logic                    y_ready;
  logic [DATA_WIDTH-1:0]   y_data;
  logic                    y_last;
  // combinational cell
  logic [DATA_WIDTH-1:0]   cell_x;
  logic [DATA_WIDTH-1:0]   cell_h_in;
  logic [9*DATA_WIDTH-1:0] cell_wts;
  logic [DATA_WIDTH-1:0]   cell_h_out;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, x_valid, x_data, y_ready, cell_h_out,
    output busy, done, x_ready, y_valid, y_data, y_last, cell_x, cell_h_in, cell_wts
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, x_valid, x_data, y_ready, cell_h_out,
    input  busy, done, x_ready, y_valid, y_data, y_last, cell_x, cell_h_in, cell_wts
  );
endinterface

// File: rtl/gru_cfg_regfile.sv
// Weight/bias and seq_len registers for the sequencer; h_init writes are forwarded as a load strobe.
// Latency: a write is visible on cell_wts/seq_len the cycle after the accepting edge.
// Backpressure: none; writes are dropped while busy or to reserved addresses.
// Ports: clk/rst_n, busy (write gate), cfg_we/cfg_addr/cfg_wdata in;
//        cell_wts (Wz in LSBs), seq_len, hinit_vld/hinit_dat out.
module gru_cfg_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   busy,
  input  logic                                   cfg_we,
  input  logic [3:0]                             cfg_addr,
  input  logic [DATA_WIDTH-1:0]                  cfg_wdata,
  output logic [gru_pkg::NUM_WTS*DATA_WIDTH-1:0] cell_wts,
  output logic [SEQ_W-1:0]                       seq_len,
  output logic                                   hinit_vld,
  output logic [DATA_WIDTH-1:0]                  hinit_dat
);
  import gru_pkg::*;

  logic [DATA_WIDTH-1:0] wts_q [NUM_WTS];
  logic [DATA_WIDTH-1:0] wts_d [NUM_WTS];
  logic [SEQ_W-1:0]      seq_len_q;
  logic [SEQ_W-1:0]      seq_len_d;
  logic                  wr_en;

  assign wr_en = cfg_we & ~busy;

  always_comb begin
    wts_d     = wts_q;
    seq_len_d = seq_len_q;
    if (wr_en) begin
      if (cfg_addr <= ADDR_BH) begin
        wts_d[cfg_addr] = cfg_wdata;
      end else if (cfg_addr == ADDR_SEQLEN) begin
        seq_len_d = cfg_wdata[SEQ_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WTS; i++) begin
        wts_q[i] <= '0;
      end
      seq_len_q <= '0;
    end else begin
      wts_q     <= wts_d;
      seq_len_q <= seq_len_d;
    end
  end

  always_comb begin
    cell_wts = '0;
    for (int i = 0; i < NUM_WTS; i++) begin
      cell_wts[i*DATA_WIDTH +: DATA_WIDTH] = wts_q[i];
    end
  end

  assign seq_len = seq_len_q;

  // h_state lives in the sequencer; it is loaded directly from this strobe.
  assign hinit_vld = wr_en && (cfg_addr == ADDR_HINIT);
  assign hinit_dat = cfg_wdata;

endmodule

// File: rtl/gru_seq_ctrl.sv
// Steps a combinational GRU/LSTM cell over an X stream, feeding h_out back as h_in each step.
// Latency: X accepted in cycle c -> y_valid in cycle c+CELL_LAT+1; one step per CELL_LAT+2 cycles.
// Backpressure: y_ready low holds the result and all state; x_ready is high only while waiting for X.
// Ports: clk, rst_n; bus (slave) carries config, start/busy/done, X and Y streams, cell interface.
module gru_seq_ctrl #(
  parameter int DATA_WIDTH  = gru_pkg::DATA_WIDTH,
  parameter int FRACT_WIDTH = gru_pkg::FRACT_WIDTH,
  parameter int CELL_LAT    = 2,
  parameter int SEQ_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  gru_seq_ctrl_if.slave  bus
);
  import gru_pkg::*;

  // The sequencer only moves words around, but a format with no integer bits
  // or a zero settle time would not describe a usable cell.
  if (CELL_LAT < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_param
    $error("gru_seq_ctrl: illegal CELL_LAT/FRACT_WIDTH");
  end

  localparam int CNT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

  state_t                state_q, state_d;
  logic [SEQ_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cell_x_q, cell_x_d;
  logic [DATA_WIDTH-1:0] y_data_q, y_data_d;
  logic [DATA_WIDTH-1:0] h_state_q, h_state_d;

  logic                  busy;
  logic [SEQ_W-1:0]      seq_len;
  logic                  hinit_vld;
  logic [DATA_WIDTH-1:0] hinit_dat;
  logic                  last_step;
  logic                  settle_end;

  gru_cfg_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEQ_W      (SEQ_W)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy      (busy),
    .cfg_we    (bus.cfg_we),
    .cfg_addr  (bus.cfg_addr),
    .cfg_wdata (bus.cfg_wdata),
    .cell_wts  (bus.cell_wts),
    .seq_len   (seq_len),
    .hinit_vld (hinit_vld),
    .hinit_dat (hinit_dat)
  );

  assign busy       = (state_q != ST_IDLE);
  // seq_len is nonzero whenever EMIT is reached, so the subtraction cannot underflow there.
  assign last_step  = (step_q == (seq_len - SEQ_W'(1)));
  assign settle_end = (cnt_q == CNT_W'(CELL_LAT - 1));

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    cell_x_d  = cell_x_q;
    y_data_d  = y_data_q;
    h_state_d = h_state_q;
    case (state_q)
      ST_IDLE: begin
        if (hinit_vld) begin
          h_state_d = hinit_dat;
        end
        if (bus.start) begin
          step_d  = '0;
          state_d = (seq_len != '0) ? ST_WAIT_X : ST_DONE;
        end
      end
      ST_WAIT_X: begin
        if (bus.x_valid) begin
          cell_x_d = bus.x_data;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_end) begin
          // h_out still reflects the old h_state here; both copies update together.
          y_data_d  = bus.cell_h_out;
          h_state_d = bus.cell_h_out;
          state_d   = ST_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        if (bus.y_ready) begin
          if (last_step) begin
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + SEQ_W'(1);
            state_d = ST_WAIT_X;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      cell_x_q  <= '0;
      y_data_q  <= '0;
      h_state_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      cell_x_q  <= cell_x_d;
      y_data_q  <= y_data_d;
      h_state_q <= h_state_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.x_ready   = (state_q == ST_WAIT_X);
  assign bus.y_valid   = (state_q == ST_EMIT);
  assign bus.y_last    = (state_q == ST_EMIT) && last_step;
  assign bus.y_data    = y_data_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.cell_x    = cell_x_q;
  assign bus.cell_h_in = h_state_q;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with a stub cell computing h_out = X + h_in.
// Latency: inputs driven 1ns after the rising edge, outputs read at that same point.
// Backpressure: y_ready is driven per step by each scenario.
module tb_gru_seq_ctrl;
  localparam int DW       = 16;
  localparam int CELL_LAT = 2;
  localparam int SEQ_W    = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  gru_seq_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  gru_seq_ctrl #(
    .DATA_WIDTH  (DW),
    .FRACT_WIDTH (12),
    .CELL_LAT    (CELL_LAT),
    .SEQ_W       (SEQ_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stub cell
  assign bus.cell_h_out = bus.cell_x + bus.cell_h_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic ack();
    bus.y_ready = 1'b1;
    tick();
    bus.y_ready = 1'b0;
  endtask

  // Waits for x_ready, hands over x, then counts cycles from the handshake cycle
  // to the first cycle with y_valid. lat = -1 when x_ready never came.
  task automatic run_step(input logic [15:0] x, output int lat,
                          output logic [15:0] yd, output logic yl);
    int n;
    n   = 0;
    lat = -1;
    yd  = '0;
    yl  = 1'b0;
    while (!bus.x_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.x_ready) return;
    bus.x_valid = 1'b1;
    bus.x_data  = x;
    tick();
    bus.x_valid = 1'b0;
    lat = 1;
    while (!bus.y_valid && lat < 20) begin
      tick();
      lat++;
    end
    yd = bus.y_data;
    yl = bus.y_last;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({bus.busy, bus.x_ready, bus.y_valid, bus.y_last, bus.done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {bus.busy, bus.x_ready, bus.y_valid, bus.y_last, bus.done});
    end
    total++;
    if ({bus.y_data, bus.cell_x, bus.cell_h_in} !== 48'h0 || bus.cell_wts !== '0) begin
      bad++;
      $display("FAIL reset_data y=%h x=%h h=%h wts=%h want all 0",
               bus.y_data, bus.cell_x, bus.cell_h_in, bus.cell_wts);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    int lat;
    logic [15:0] yd;
    logic yl;
    logic [15:0] exp_y [3];
    exp_y[0] = 16'h1400;
    exp_y[1] = 16'h1800;
    exp_y[2] = 16'h1C00;
    cfg_write(4'd9, 16'h1000);
    cfg_write(4'd10, 16'd3);
    total++;
    if (bus.cell_h_in !== 16'h1000) begin
      bad++;
      $display("FAIL hinit_load got=%h want=1000", bus.cell_h_in);
    end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      run_step(16'h0400, lat, yd, yl);
      total++;
      if (lat !== CELL_LAT + 1) begin
        bad++;
        $display("FAIL seq_latency step=%0d got=%0d want=%0d", i, lat, CELL_LAT + 1);
      end
      total++;
      if (yd !== exp_y[i]) begin
        bad++;
        $display("FAIL seq_ydata step=%0d got=%h want=%h", i, yd, exp_y[i]);
      end
      total++;
      if (yl !== (i == 2)) begin
        bad++;
        $display("FAIL seq_ylast step=%0d got=%b want=%b", i, yl, (i == 2));
      end
      ack();
    end
    total++;
    if (bus.done !== 1'b1 || bus.y_valid !== 1'b0) begin
      bad++;
      $display("FAIL seq_done_pulse done=%b y_valid=%b want 1 0", bus.done, bus.y_valid);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL seq_back_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_continue();
    int lat;
    logic [15:0] yd;
    logic yl;
    cfg_write(4'd10, 16'd1);
    total++;
    if (bus.cell_h_in !== 16'h1C00) begin
      bad++;
      $display("FAIL cont_hold_h got=%h want=1c00", bus.cell_h_in);
    end
    pulse_start();
    run_step(16'h0400, lat, yd, yl);
    total++;
    if (yd !== 16'h2000 || yl !== 1'b1) begin
      bad++;
      $display("FAIL cont_ydata got=%h last=%b want=2000 1", yd, yl);
    end
    ack();
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] yd;
    logic yl;
    cfg_write(4'd9, 16'h0100);
    cfg_write(4'd10, 16'd2);
    pulse_start();
    run_step(16'h0200, lat, yd, yl);
    total++;
    if (yd !== 16'h0300 || yl !== 1'b0) begin
      bad++;
      $display("FAIL bp_first got=%h last=%b want=0300 0", yd, yl);
    end
    // x offered during the stall must be ignored
    bus.x_valid = 1'b1;
    bus.x_data  = 16'h7777;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (bus.y_valid !== 1'b1 || bus.y_data !== 16'h0300 || bus.x_ready !== 1'b0 ||
          bus.cell_x !== 16'h0200 || bus.cell_h_in !== 16'h0300) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d vld=%b y=%h xrdy=%b cx=%h h=%h want 1 0300 0 0200 0300",
                 k, bus.y_valid, bus.y_data, bus.x_ready, bus.cell_x, bus.cell_h_in);
      end
    end
    bus.x_valid = 1'b0;
    ack();
    run_step(16'h0100, lat, yd, yl);
    total++;
    if (lat !== CELL_LAT + 1 || yd !== 16'h0400 || yl !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume lat=%0d y=%h last=%b want %0d 0400 1", lat, yd, yl, CELL_LAT + 1);
    end
    ack();
    tick();
  endtask

  task automatic test_cfg_busy();
    int lat;
    logic [15:0] yd;
    logic yl;
    pulse_start();
    cfg_write(4'd0, 16'h0402);
    cfg_write(4'd10, 16'd5);
    cfg_write(4'd9, 16'h7000);
    total++;
    if (bus.cell_wts !== '0 || bus.cell_h_in !== 16'h0400) begin
      bad++;
      $display("FAIL busy_write wts=%h h=%h want 0 0400", bus.cell_wts, bus.cell_h_in);
    end
    run_step(16'h0100, lat, yd, yl);
    total++;
    if (yd !== 16'h0500 || yl !== 1'b0) begin
      bad++;
      $display("FAIL busy_step1 got=%h last=%b want=0500 0", yd, yl);
    end
    ack();
    run_step(16'h0100, lat, yd, yl);
    total++;
    if (yd !== 16'h0600 || yl !== 1'b1) begin
      bad++;
      $display("FAIL busy_seqlen_kept got=%h last=%b want=0600 1", yd, yl);
    end
    ack();
    tick();
    cfg_write(4'd0, 16'h0402);
    cfg_write(4'd8, 16'hABCD);
    cfg_write(4'd12, 16'h5555);
    total++;
    if (bus.cell_wts[15:0] !== 16'h0402 || bus.cell_wts[143:128] !== 16'hABCD ||
        bus.cell_wts[127:16] !== '0 || bus.cell_h_in !== 16'h0600) begin
      bad++;
      $display("FAIL idle_write wz=%h bh=%h mid=%h h=%h want 0402 abcd 0 0600",
               bus.cell_wts[15:0], bus.cell_wts[143:128], bus.cell_wts[127:16], bus.cell_h_in);
    end
  endtask

  task automatic test_seq_len_zero();
    int seen_done;
    int seen_y;
    seen_done = 0;
    seen_y    = 0;
    cfg_write(4'd10, 16'd0);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      if (bus.done === 1'b1 && k < 2) seen_done++;
      if (bus.y_valid !== 1'b0) seen_y++;
      tick();
    end
    total++;
    if (seen_done !== 1) begin
      bad++;
      $display("FAIL zero_done_pulse got=%0d want=1", seen_done);
    end
    total++;
    if (seen_y !== 0 || bus.cell_h_in !== 16'h0600 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_no_steps yv=%0d h=%h busy=%b want 0 0600 0", seen_y, bus.cell_h_in, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    int seen_done;
    logic [15:0] yd;
    logic yl;
    n = 0;
    seen_done = 0;
    cfg_write(4'd9, 16'h1000);
    cfg_write(4'd10, 16'd3);
    pulse_start();
    run_step(16'h0400, lat, yd, yl);
    ack();
    while (!bus.x_ready && n < 20) begin
      tick();
      n++;
    end
    bus.x_valid = 1'b1;
    bus.x_data  = 16'h0400;
    tick();
    bus.x_valid = 1'b0;
    total++;
    if (bus.x_ready !== 1'b0 || bus.busy !== 1'b1 || bus.cell_x !== 16'h0400) begin
      bad++;
      $display("FAIL mid_in_settle xrdy=%b busy=%b cx=%h want 0 1 0400", bus.x_ready, bus.busy, bus.cell_x);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.x_ready, bus.y_valid, bus.y_last, bus.done} !== 5'b0 ||
        {bus.y_data, bus.cell_x, bus.cell_h_in} !== 48'h0 || bus.cell_wts !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs ctrl=%b y=%h x=%h h=%h wts=%h want all 0",
               {bus.busy, bus.x_ready, bus.y_valid, bus.y_last, bus.done},
               bus.y_data, bus.cell_x, bus.cell_h_in, bus.cell_wts);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
      tick();
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d want=0", seen_done);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.start     = 1'b0;
    bus.x_valid   = 1'b0;
    bus.x_data    = '0;
    bus.y_ready   = 1'b0;
    test_reset();
    test_sequence();
    test_continue();
    test_backpressure();
    test_cfg_busy();
    test_seq_len_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
